// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Control bundles are built from named helpers so the decode reads as intent.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_MD_DONE = 2'd2
  } state_t;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_zero;
    logic idex_en;
    logic idex_zero;
    logic exmem_en;
    logic exmem_zero;
    logic memwb_en;
  } ctrl_t;

  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_zero: 1'b0, idex_en: 1'b1,
          idex_zero: 1'b0, exmem_en: 1'b1, exmem_zero: 1'b0, memwb_en: 1'b1};
    return c;
  endfunction

  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_zero: 1'b1, idex_en: 1'b0,
          idex_zero: 1'b1, exmem_en: 1'b0, exmem_zero: 1'b1, memwb_en: 1'b0};
    return c;
  endfunction

  // Front end frozen, the older instruction drains, a bubble enters MEM.
  function automatic ctrl_t ctrl_md_stall();
    ctrl_t c;
    c = ctrl_default();
    c.pc_en      = 1'b0;
    c.ifid_en    = 1'b0;
    c.idex_en    = 1'b0;
    c.exmem_zero = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_branch();
    ctrl_t c;
    c = ctrl_default();
    c.ifid_zero = 1'b1;
    c.idex_zero = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c = ctrl_default();
    c.pc_en     = 1'b0;
    c.ifid_en   = 1'b0;
    c.idex_zero = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// Load-use comparator: flags an ID source operand that the load in EX will write.
// Register zero is never a real dependency.
module lu_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                ex_memread,
  input  logic [REG_BITS-1:0] ex_rd,
  output logic                lu
);

  logic [REG_BITS-1:0] src_idx [2];
  logic [1:0]          src_use;
  logic [1:0]          src_hit;
  logic                rd_live;

  assign src_idx[0] = id_rs;
  assign src_idx[1] = id_rt;
  assign src_use    = {id_use_rt, id_use_rs};
  assign rd_live    = (ex_rd != REG_BITS'(REG_ZERO));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] && (src_idx[gi] == ex_rd);
    end
  endgenerate

  assign lu = ex_memread && rd_live && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF_ID, ID_EX, EX_MEM and MEM_WB registers.
// Holds the front end for fixed-latency mult/div, bubbles load-use, squashes on taken branch.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_BITS  = 5,
  parameter int MD_CYCLES = 32,
  parameter int CNT_BITS  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                ex_memread,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_md,
  input  logic                ex_br_taken,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_zero,
  output logic                idex_en,
  output logic                idex_zero,
  output logic                exmem_en,
  output logic                exmem_zero,
  output logic                memwb_en,
  output logic                md_busy
);

  state_t              state_reg, state_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                lu;
  ctrl_t               ctrl;

  lu_detect #(
    .REG_BITS(REG_BITS)
  ) u_lu_detect (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .ex_memread(ex_memread),
    .ex_rd     (ex_rd),
    .lu        (lu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ctrl       = ctrl_default();
    case (state_reg)
      ST_MD_WAIT: begin
        ctrl     = ctrl_md_stall();
        cnt_next = cnt_reg - CNT_BITS'(1);
        if (cnt_reg == CNT_BITS'(1)) begin
          state_next = ST_MD_DONE;
        end
      end
      ST_RUN, ST_MD_DONE: begin
        // The start cycle is itself the first of the MD_CYCLES stall cycles.
        if (state_reg == ST_RUN && ex_md) begin
          ctrl       = ctrl_md_stall();
          cnt_next   = CNT_BITS'(MD_CYCLES - 1);
          state_next = ST_MD_WAIT;
        end else begin
          if (ex_br_taken) begin
            ctrl = ctrl_branch();
          end else if (lu) begin
            ctrl = ctrl_load_use();
          end
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
    if (rst) begin
      ctrl = ctrl_reset();
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_zero  = ctrl.ifid_zero;
  assign idex_en    = ctrl.idex_en;
  assign idex_zero  = ctrl.idex_zero;
  assign exmem_en   = ctrl.exmem_en;
  assign exmem_zero = ctrl.exmem_zero;
  assign memwb_en   = ctrl.memwb_en;
  assign md_busy    = (state_reg == ST_MD_WAIT) && !rst;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checks of pipe_hazard_ctrl against a cycle-level reference model.
// Two instances: a short (4-cycle) and a long (12-cycle) mult/div latency.
module tb_pipe_hazard_ctrl;

  localparam int RB   = 5;
  localparam int MD_A = 4;
  localparam int MD_B = 12;

  // Output vector order: {pc_en, ifid_en, ifid_zero, idex_en, idex_zero,
  //                       exmem_en, exmem_zero, memwb_en, md_busy}
  localparam logic [8:0] P_RESET = 9'b001010100;
  localparam logic [8:0] P_BUSY  = 9'b000001111;
  localparam logic [8:0] P_START = 9'b000001110;
  localparam logic [8:0] P_BR    = 9'b111111010;
  localparam logic [8:0] P_LU    = 9'b000111010;
  localparam logic [8:0] P_DEF   = 9'b110101010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [RB-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0, ex_memread = 1'b0;
  logic          ex_md = 1'b0, ex_br_taken = 1'b0;

  logic a_pc_en, a_ifid_en, a_ifid_zero, a_idex_en, a_idex_zero;
  logic a_exmem_en, a_exmem_zero, a_memwb_en, a_md_busy;
  logic b_pc_en, b_ifid_en, b_ifid_zero, b_idex_en, b_idex_zero;
  logic b_exmem_en, b_exmem_zero, b_memwb_en, b_md_busy;
  logic [8:0] a_vec, b_vec;

  assign a_vec = {a_pc_en, a_ifid_en, a_ifid_zero, a_idex_en, a_idex_zero,
                  a_exmem_en, a_exmem_zero, a_memwb_en, a_md_busy};
  assign b_vec = {b_pc_en, b_ifid_en, b_ifid_zero, b_idex_en, b_idex_zero,
                  b_exmem_en, b_exmem_zero, b_memwb_en, b_md_busy};

  pipe_hazard_ctrl #(.REG_BITS(RB), .MD_CYCLES(MD_A), .CNT_BITS(3)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_md(ex_md),
    .ex_br_taken(ex_br_taken), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
    .ifid_zero(a_ifid_zero), .idex_en(a_idex_en), .idex_zero(a_idex_zero),
    .exmem_en(a_exmem_en), .exmem_zero(a_exmem_zero), .memwb_en(a_memwb_en),
    .md_busy(a_md_busy));

  pipe_hazard_ctrl #(.REG_BITS(RB), .MD_CYCLES(MD_B), .CNT_BITS(4)) dut_long (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_md(ex_md),
    .ex_br_taken(ex_br_taken), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
    .ifid_zero(b_ifid_zero), .idex_en(b_idex_en), .idex_zero(b_idex_zero),
    .exmem_en(b_exmem_en), .exmem_zero(b_exmem_zero), .memwb_en(b_memwb_en),
    .md_busy(b_md_busy));

  always @(posedge clk) begin
    assert (!(ex_md && ex_br_taken)) else $error("ex_md and ex_br_taken high together");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: stall cycles still owed after this one, and whether the op just finished.
  int busy_left [2] = '{0, 0};
  bit after_md  [2] = '{1'b0, 1'b0};
  int md_len    [2] = '{MD_A, MD_B};

  function automatic logic [8:0] model_out(int k);
    bit lu_m;
    lu_m = ex_memread && (ex_rd != 0) &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (rst)                      return P_RESET;
    if (busy_left[k] > 0)         return P_BUSY;
    if (ex_md && !after_md[k])    return P_START;
    if (ex_br_taken)              return P_BR;
    if (lu_m)                     return P_LU;
    return P_DEF;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy_left[k] = 0;
        after_md[k]  = 1'b0;
      end else if (busy_left[k] > 0) begin
        busy_left[k] = busy_left[k] - 1;
        after_md[k]  = (busy_left[k] == 0);
      end else if (ex_md && !after_md[k]) begin
        busy_left[k] = md_len[k] - 1;
        after_md[k]  = 1'b0;
      end else begin
        after_md[k] = 1'b0;
      end
    end
  endtask

  // Advances the model over the edge just taken, then presents the next cycle's inputs.
  task automatic apply(input bit r, input bit md, input bit br, input bit mr,
                       input int rd, input int rs, input int rt, input bit urs, input bit urt);
    @(negedge clk);
    model_step();
    rst = r; ex_md = md; ex_br_taken = br; ex_memread = mr;
    ex_rd = RB'(rd); id_rs = RB'(rs); id_rt = RB'(rt); id_use_rs = urs; id_use_rt = urt;
    #1;
    cyc++;
    $display("cyc %0d rst=%0b md=%0b br=%0b ld=%0b rd=%0d rs=%0d/%0b rt=%0d/%0b a=%b b=%b",
             cyc, r, md, br, mr, rd, rs, urs, rt, urt, a_vec, b_vec);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (a_vec !== P_RESET || b_vec !== P_RESET) begin
        errors++;
        $display("FAIL reset_hold: a=%b b=%b expected %b", a_vec, b_vec, P_RESET);
      end
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec !== P_DEF || b_vec !== P_DEF) begin
      errors++;
      $display("FAIL reset_release: a=%b b=%b expected %b", a_vec, b_vec, P_DEF);
    end
  endtask

  task automatic test_load_use();
    apply(0, 0, 0, 1, 8, 8, 3, 1, 0);
    checks++;
    if (a_vec !== P_LU || b_vec !== P_LU) begin
      errors++;
      $display("FAIL lu_rs: a=%b b=%b expected %b", a_vec, b_vec, P_LU);
    end
    apply(0, 0, 0, 0, 8, 8, 3, 1, 0);
    checks++;
    if (a_vec !== P_DEF) begin
      errors++;
      $display("FAIL lu_after: a=%b expected %b", a_vec, P_DEF);
    end
    apply(0, 0, 0, 1, 5, 2, 5, 0, 1);
    checks++;
    if (a_vec !== P_LU) begin
      errors++;
      $display("FAIL lu_rt: a=%b expected %b", a_vec, P_LU);
    end
    apply(0, 0, 0, 1, 5, 5, 2, 0, 1);
    checks++;
    if (a_vec !== P_DEF) begin
      errors++;
      $display("FAIL lu_unused_src: a=%b expected %b", a_vec, P_DEF);
    end
    apply(0, 0, 0, 1, 0, 0, 0, 1, 1);
    checks++;
    if (a_vec !== P_DEF || b_vec !== P_DEF) begin
      errors++;
      $display("FAIL lu_rd_zero: a=%b b=%b expected %b", a_vec, b_vec, P_DEF);
    end
  endtask

  task automatic test_md();
    int stalls = 0, busy = 0;
    bit done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (a_vec !== model_out(0) || b_vec !== model_out(1)) begin
        errors++;
        $display("FAIL md_model: a=%b b=%b expected %b %b", a_vec, b_vec, model_out(0), model_out(1));
      end
      if (a_pc_en === 1'b0) stalls++;
      if (a_md_busy === 1'b1) busy++;
      if (a_pc_en === 1'b1 && stalls > 0) begin
        done = 1'b1;
        checks++;
        if (a_vec !== P_DEF) begin
          errors++;
          $display("FAIL md_done_cycle: a=%b expected %b", a_vec, P_DEF);
        end
      end
    end
    checks++;
    if (!done || stalls != MD_A || busy != MD_A - 1) begin
      errors++;
      $display("FAIL md_length: done=%0b stalls=%0d busy=%0d expected stalls=%0d busy=%0d",
               done, stalls, busy, MD_A, MD_A - 1);
    end
    for (int i = 0; i < MD_B; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (a_vec !== model_out(0) || b_vec !== model_out(1)) begin
        errors++;
        $display("FAIL md_drain: a=%b b=%b expected %b %b", a_vec, b_vec, model_out(0), model_out(1));
      end
    end
  endtask

  task automatic test_branch_lu();
    apply(0, 0, 1, 1, 8, 8, 8, 1, 1);
    checks++;
    if (a_vec !== P_BR || b_vec !== P_BR) begin
      errors++;
      $display("FAIL br_over_lu: a=%b b=%b expected %b", a_vec, b_vec, P_BR);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (a_vec !== P_DEF) begin
      errors++;
      $display("FAIL br_no_stall: a=%b expected %b", a_vec, P_DEF);
    end
  endtask

  task automatic test_reset_abort();
    int stalls = 0;
    bit done = 1'b0;
    // Third cycle of the long op has cnt == 10.
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (b_vec !== P_RESET) begin
      errors++;
      $display("FAIL abort_rst: b=%b expected %b", b_vec, P_RESET);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (b_md_busy !== 1'b0 || b_vec !== P_DEF || a_vec !== P_DEF) begin
      errors++;
      $display("FAIL abort_run: a=%b b=%b expected %b", a_vec, b_vec, P_DEF);
    end
    for (int i = 0; i < 30 && !done; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (a_vec !== model_out(0) || b_vec !== model_out(1)) begin
        errors++;
        $display("FAIL abort_model: a=%b b=%b expected %b %b", a_vec, b_vec, model_out(0), model_out(1));
      end
      if (b_pc_en === 1'b0) stalls++;
      else if (stalls > 0) done = 1'b1;
    end
    checks++;
    if (!done || stalls != MD_B) begin
      errors++;
      $display("FAIL abort_fresh_len: done=%0b stalls=%0d expected %0d", done, stalls, MD_B);
    end
    for (int i = 0; i < MD_A + 2; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_branch_in_wait();
    int sa = 0, sb = 0;
    for (int i = 0; i < MD_B + 3; i++) begin
      apply(0, i == 0, i > 0 && i < 8, 1, 4, 4, 0, 1, 0);
      checks++;
      if (a_vec !== model_out(0) || b_vec !== model_out(1)) begin
        errors++;
        $display("FAIL wait_br_model: a=%b b=%b expected %b %b", a_vec, b_vec, model_out(0), model_out(1));
      end
      if (a_exmem_zero === 1'b1) sa++;
      if (b_exmem_zero === 1'b1) sb++;
    end
    checks++;
    if (sa != MD_A || sb != MD_B) begin
      errors++;
      $display("FAIL wait_br_len: a=%0d b=%0d expected %0d %0d", sa, sb, MD_A, MD_B);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit r, md, br;
      r  = ($urandom % 50) == 0;
      md = ($urandom % 10) == 0;
      br = !md && (($urandom % 5) == 0);
      apply(r, md, br, $urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4,
            $urandom % 2, $urandom % 2);
      checks++;
      if (a_vec !== model_out(0) || b_vec !== model_out(1)) begin
        errors++;
        $display("FAIL random: a=%b b=%b expected %b %b", a_vec, b_vec, model_out(0), model_out(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_md();
    test_branch_lu();
    test_reset_abort();
    test_branch_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
